cnt_if: RTL and testbench

// - Loadable up/down binary counter with an all-ones (rollover) status flag.
// - Leaf datapath block for testbench and interface bring-up.
// - Driven by a simple control bundle: load, load_en, down.
// - No handshake; one count step per clock.
//

---
 rtl/cnt_if.sv | 46 ++++
 tb/tb_cnt_if.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_if.sv
// Loadable up/down binary counter with an all-ones (rollover) status flag.
// Define CNT_IF_SATURATE_EN to clamp at 0 / all-ones instead of wrapping.
module cnt_if #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] load,
  input  logic             load_en,
  input  logic             down,
  output logic             rollover,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // Next-count selection: load beats direction; load is ignored entirely otherwise.
  always_comb begin
    w_count_nxt = r_count;
    if (load_en) begin
      w_count_nxt = load;
    end else if (down) begin
`ifdef CNT_IF_SATURATE_EN
      if (r_count != '0) w_count_nxt = r_count - WIDTH'(1);
`else
      w_count_nxt = r_count - WIDTH'(1);
`endif
    end else begin
`ifdef CNT_IF_SATURATE_EN
      if (r_count != '1) w_count_nxt = r_count + WIDTH'(1);
`else
      w_count_nxt = r_count + WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_count <= '0;
    else       r_count <= w_count_nxt;
  end

  assign count    = r_count;
  assign rollover = &r_count;

endmodule

// File: tb/tb_cnt_if.sv
// Self-checking bench for cnt_if (WIDTH=4): directed scenarios plus randomized
// stimulus against an integer reference model.
module tb_cnt_if;

  localparam int unsigned WIDTH = 4;
  localparam int          MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] load;
  logic             load_en;
  logic             down;
  logic             rollover;
  logic [WIDTH-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_if #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_en  (load_en),
    .down     (down),
    .rollover (rollover),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference next value from the counting rules, in plain integer arithmetic.
  function automatic int model_next(int c, bit le, bit dn, int ld);
    if (le) return ld;
`ifdef CNT_IF_SATURATE_EN
    if (dn) return (c == 0) ? 0 : c - 1;
    return (c == MAXV) ? MAXV : c + 1;
`else
    if (dn) return (c + MAXV) % (MAXV + 1);
    return (c + 1) % (MAXV + 1);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; load_en = 1'b0; down = 1'b0; load = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (count !== 4'h0) begin
      n_fail++; $display("FAIL reset_count: got %h want 0", count);
    end
    n_checks++;
    if (rollover !== 1'b0) begin
      n_fail++; $display("FAIL reset_rollover: got %b want 0", rollover);
    end
  endtask

  task automatic test_count_up();
    int exp;
    rstn = 1'b1; down = 1'b0; load_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = i % 16;
      n_checks++;
      if (count !== 4'(exp)) begin
        n_fail++; $display("FAIL count_up step %0d: got %h want %h", i, count, exp);
      end
      n_checks++;
      if (rollover !== (exp == MAXV)) begin
        n_fail++; $display("FAIL count_up_rollover step %0d: got %b want %b", i, rollover, exp == MAXV);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    n_checks++;
    if (count !== 4'h3) begin
      n_fail++; $display("FAIL pre_async_count: got %h want 3", count);
    end
    #3 rstn = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0 before next edge", count);
    end
    @(negedge clk);
  endtask

  task automatic test_count_down();
    int exp1, exp2;
`ifdef CNT_IF_SATURATE_EN
    exp1 = 0; exp2 = 0;
`else
    exp1 = 15; exp2 = 14;
`endif
    down = 1'b1; load_en = 1'b0; rstn = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'(exp1) || rollover !== (exp1 == MAXV)) begin
      n_fail++; $display("FAIL count_down_1: got %h/%b want %h/%b", count, rollover, exp1, exp1 == MAXV);
    end
    tick();
    n_checks++;
    if (count !== 4'(exp2) || rollover !== (exp2 == MAXV)) begin
      n_fail++; $display("FAIL count_down_2: got %h/%b want %h/%b", count, rollover, exp2, exp2 == MAXV);
    end
  endtask

  task automatic test_load_priority();
    load = 4'h3; load_en = 1'b1; down = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'h3) begin
      n_fail++; $display("FAIL load_3: got %h want 3", count);
    end
    load = 4'hA; load_en = 1'b1; down = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'hA) begin
      n_fail++; $display("FAIL load_priority: got %h want a", count);
    end
    load_en = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'h9) begin
      n_fail++; $display("FAIL after_load_dec1: got %h want 9", count);
    end
    tick();
    n_checks++;
    if (count !== 4'h8) begin
      n_fail++; $display("FAIL after_load_dec2: got %h want 8", count);
    end
  endtask

  task automatic test_load_all_ones();
    int exp;
    load = 4'hF; load_en = 1'b1; down = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'hF || rollover !== 1'b1) begin
      n_fail++; $display("FAIL load_ones: got %h/%b want f/1", count, rollover);
    end
`ifdef CNT_IF_SATURATE_EN
    exp = 15;
`else
    exp = 0;
`endif
    load_en = 1'b0; load = 4'h5;
    tick();
    n_checks++;
    if (count !== 4'(exp) || rollover !== (exp == MAXV)) begin
      n_fail++; $display("FAIL ones_then_up: got %h/%b want %h/%b", count, rollover, exp, exp == MAXV);
    end
  endtask

  task automatic test_random();
    int  m;
    bit  le, dn;
    int  ld;
    bit  done;
    load = 4'h0; load_en = 1'b1; down = 1'b0;
    tick();
    m = 0;
    n_checks++;
    if (count !== 4'h0) begin
      n_fail++; $display("FAIL random_init: got %h want 0", count);
    end
    done = 1'b0;
    fork
      begin
        repeat (300) begin
          @(posedge clk);
          le = load_en; dn = down; ld = int'(load);
          m = model_next(m, le, dn, ld);
          @(negedge clk);
          n_checks++;
          if (count !== 4'(m) || rollover !== (m == MAXV)) begin
            n_fail++;
            $display("FAIL random t=%0t: got %h/%b want %h/%b", $time, count, rollover, m, m == MAXV);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          #($urandom_range(30, 1));
          if ($time % 20 == 10) #1;
          load    = 4'($urandom_range(MAXV, 0));
          load_en = ($urandom_range(3, 0) == 0);
          down    = 1'($urandom_range(1, 0));
        end
      end
    join
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_async_reset();
    test_count_down();
    test_load_priority();
    test_load_all_ones();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
